pio_irq_servicer: RTL and testbench
===================================

// Module: pio_irq_servicer
// PURPOSE
//  Avalon-MM host that services the 10-bit edge-capture input PIO on its irq: programs
//  irq_mask once after reset, then on each irq reads edge_capture (reg 3), clears it,
//  reads data (reg 0) and hands {edges,data} to fabric logic through a valid/ready port.
//  Sits between the PIO slave (via interconnect) and hardware consumers of key/switch events.
// PARAMETERS
//  BASE_ADDR  0      byte base address of the PIO; reg n is at BASE_ADDR + 4*n
//  ADDR_W     16     avm_address width
//  IRQ_MASK   10'h3FF value written to irq_mask (reg 2) during init
//  TIMEOUT    255    max consecutive waitrequest cycles (only with PIO_SVC_TIMEOUT_EN)
// PORTS
//  clk             in   1       system clock
//  reset           in   1       asynchronous, active-high reset
//  pio_irq         in   1       level irq from PIO
//  avm_address     out  ADDR_W  byte address
//  avm_read        out  1       read request
//  avm_write       out  1       write request
//  avm_writedata   out  32      write data
//  avm_readdata    in   32      read data, valid in cycle waitrequest is low on a read
//  avm_waitrequest in   1       stall; hold command stable while high
//  evt_valid       out  1       event available
//  evt_ready       in   1       consumer accepts event
//  evt_edges       out  10      edge_capture snapshot
//  evt_data        out  10      data register snapshot
//  init_done       out  1       irq_mask programmed
//  err             out  1       sticky bus timeout (0 when macro off)
// BEHAVIOUR
//  - Single clock; reset is asynchronous, active-high, clock is clk.
//  - Reset: avm_read=avm_write=0, avm_address=BASE_ADDR, avm_writedata=0, evt_valid=0,
//    evt_edges=evt_data=0, init_done=0, err=0, state=INIT. Reset mid-transfer drops the
//    command immediately; no completion is awaited.
//  - All outputs registered. Command accepted in the cycle avm_waitrequest==0; command held
//    stable (address, data, strobes) while waitrequest==1. Never read and write together.
//  - FSM:
//    INIT:     write reg2 <= {22'b0,IRQ_MASK}; on accept -> IDLE, init_done=1 (stays 1).
//    IDLE:     pio_irq==1 -> RD_EDGE (command issued next cycle, i.e. 1-cycle irq latency).
//    RD_EDGE:  read reg3; on accept latch readdata[9:0] to evt_edges;
//              if value==0 (spurious) -> IDLE, else -> CLR_EDGE.
//    CLR_EDGE: write reg3 with latched edges (PIO clears all bits on any write) -> RD_DATA.
//    RD_DATA:  read reg0; on accept latch readdata[9:0] to evt_data -> REPORT.
//    REPORT:   evt_valid=1; evt_edges/evt_data stable; on evt_valid&&evt_ready -> IDLE,
//              evt_valid=0 next cycle. Min event interval: 5 cycles with zero wait states.
//  - readdata[31:10] ignored. Edges arriving between RD_EDGE and CLR_EDGE are lost (PIO
//    semantics); edges arriving after CLR_EDGE reassert irq and are serviced after REPORT.
//  - irq ignored outside IDLE; irq held high while in REPORT causes a new service
//    immediately on return to IDLE. irq during INIT waits for init_done.
//  - evt_ready high with evt_valid low has no effect.
// CONFIGURATION
//  PIO_SVC_TIMEOUT_EN defined: counter of consecutive waitrequest cycles in any bus state;
//    when it exceeds TIMEOUT, drop strobes, set err (sticky until reset), go IDLE (from INIT:
//    retry INIT). Counter clears on every accept and on state entry.
//  Undefined: no counter, err tied 0, host waits indefinitely on waitrequest.
// TESTING
//  1 Reset release, waitrequest=0 -> one write addr BASE+8 data 0x3FF, then init_done=1.
//  2 irq with edge_capture=0x004, data=0x3FB, no stall -> reads BASE+12, writes BASE+12
//    data 0x004, reads BASE+0; evt_valid with edges=0x004 data=0x3FB; ready=1 -> IDLE.
//  3 waitrequest held 3 cycles on each command -> commands held stable, same event result.
//  4 Spurious irq, edge_capture reads 0 -> no write, no evt_valid, back to IDLE.
//  5 evt_ready=0 for 20 cycles with irq re-asserted -> event held stable, no bus traffic;
//    after ready, second service starts next IDLE cycle.
//  6 PIO_SVC_TIMEOUT_EN, TIMEOUT=8, waitrequest stuck in RD_DATA -> strobes drop after 9
//    stall cycles, err=1 persists; reset asserted mid-read -> avm_read=0 asynchronously.

Source files
------------

// File: rtl/pio_irq_servicer.sv
// Avalon-MM host that services an edge-capture PIO irq and forwards {edges,data} on a valid/ready port.
// Optional bus-stall watchdog enabled by defining PIO_SVC_TIMEOUT_EN.
module pio_irq_servicer #(
  parameter int unsigned BASE_ADDR = 0,
  parameter int unsigned ADDR_W    = 16,
  parameter logic [9:0]  IRQ_MASK  = 10'h3FF,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pio_irq,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  output logic              avm_write,
  output logic [31:0]       avm_writedata,
  input  logic [31:0]       avm_readdata,
  input  logic              avm_waitrequest,
  output logic              evt_valid,
  input  logic              evt_ready,
  output logic [9:0]        evt_edges,
  output logic [9:0]        evt_data,
  output logic              init_done,
  output logic              err
);

  localparam logic [ADDR_W-1:0] ADDR_DATA = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] ADDR_MASK = ADDR_W'(BASE_ADDR + 8);
  localparam logic [ADDR_W-1:0] ADDR_EDGE = ADDR_W'(BASE_ADDR + 12);

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_RD_EDGE,
    S_CLR_EDGE,
    S_RD_DATA,
    S_REPORT
  } state_t;

  state_t            state_q, state_d;
  logic              read_q, read_d;
  logic              write_q, write_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              evt_valid_q, evt_valid_d;
  logic [9:0]        edges_q, edges_d;
  logic [9:0]        data_q, data_d;
  logic              init_done_q, init_done_d;
  logic              err_q, err_d;
  logic              accept;
  logic              timeout;
  logic              unused_rdata;

  assign accept       = (read_q | write_q) & ~avm_waitrequest;
  assign unused_rdata = ^avm_readdata[31:10];

`ifdef PIO_SVC_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1) + 1;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;

  // Fires on the stall cycle that would push the count past TIMEOUT.
  assign timeout = (read_q | write_q) & avm_waitrequest & (wait_cnt_q == CNT_W'(TIMEOUT));

  always_comb begin
    wait_cnt_d = '0;
    if ((read_q | write_q) && avm_waitrequest && !timeout)
      wait_cnt_d = wait_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) wait_cnt_q <= '0;
    else       wait_cnt_q <= wait_cnt_d;
  end
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = 32'(TIMEOUT);
  assign timeout        = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    read_d      = read_q;
    write_d     = write_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    evt_valid_d = evt_valid_q;
    edges_d     = edges_q;
    data_d      = data_q;
    init_done_d = init_done_q;
    err_d       = err_q;

    case (state_q)
      S_INIT: begin
        if (!write_q) begin
          write_d = 1'b1;
          addr_d  = ADDR_MASK;
          wdata_d = {22'b0, IRQ_MASK};
        end else if (accept) begin
          write_d     = 1'b0;
          init_done_d = 1'b1;
          state_d     = S_IDLE;
        end
      end
      S_IDLE: begin
        if (pio_irq) begin
          read_d  = 1'b1;
          addr_d  = ADDR_EDGE;
          state_d = S_RD_EDGE;
        end
      end
      S_RD_EDGE: begin
        if (accept) begin
          read_d  = 1'b0;
          edges_d = avm_readdata[9:0];
          if (avm_readdata[9:0] == 10'd0) begin
            state_d = S_IDLE;
          end else begin
            // Writing back the snapshot clears edge_capture; address is already reg3.
            write_d = 1'b1;
            wdata_d = {22'b0, avm_readdata[9:0]};
            state_d = S_CLR_EDGE;
          end
        end
      end
      S_CLR_EDGE: begin
        if (accept) begin
          write_d = 1'b0;
          read_d  = 1'b1;
          addr_d  = ADDR_DATA;
          state_d = S_RD_DATA;
        end
      end
      S_RD_DATA: begin
        if (accept) begin
          read_d      = 1'b0;
          data_d      = avm_readdata[9:0];
          evt_valid_d = 1'b1;
          state_d     = S_REPORT;
        end
      end
      S_REPORT: begin
        if (evt_ready) begin
          evt_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_INIT;
    endcase

    if (timeout) begin
      read_d  = 1'b0;
      write_d = 1'b0;
      err_d   = 1'b1;
      state_d = (state_q == S_INIT) ? S_INIT : S_IDLE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_INIT;
      read_q      <= 1'b0;
      write_q     <= 1'b0;
      addr_q      <= ADDR_DATA;
      wdata_q     <= '0;
      evt_valid_q <= 1'b0;
      edges_q     <= '0;
      data_q      <= '0;
      init_done_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      read_q      <= read_d;
      write_q     <= write_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      evt_valid_q <= evt_valid_d;
      edges_q     <= edges_d;
      data_q      <= data_d;
      init_done_q <= init_done_d;
      err_q       <= err_d;
    end
  end

  assign avm_address   = addr_q;
  assign avm_read      = read_q;
  assign avm_write     = write_q;
  assign avm_writedata = wdata_q;
  assign evt_valid     = evt_valid_q;
  assign evt_edges     = edges_q;
  assign evt_data      = data_q;
  assign init_done     = init_done_q;
  assign err           = err_q;

endmodule

// File: tb/tb_pio_irq_servicer.sv
// Directed bench for pio_irq_servicer with a small PIO slave model answering on the falling edge.
module tb_pio_irq_servicer;

  localparam int unsigned        ADDR_W = 16;
  localparam logic [ADDR_W-1:0]  BASE   = 16'h0100;

  logic              clk = 1'b0;
  logic              reset;
  logic              pio_irq;
  logic [ADDR_W-1:0] avm_address;
  logic              avm_read;
  logic              avm_write;
  logic [31:0]       avm_writedata;
  logic [31:0]       avm_readdata;
  logic              avm_waitrequest;
  logic              evt_valid;
  logic              evt_ready;
  logic [9:0]        evt_edges;
  logic [9:0]        evt_data;
  logic              init_done;
  logic              err;

  pio_irq_servicer #(
    .BASE_ADDR (BASE),
    .ADDR_W    (ADDR_W),
    .IRQ_MASK  (10'h3FF),
    .TIMEOUT   (8)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .pio_irq         (pio_irq),
    .avm_address     (avm_address),
    .avm_read        (avm_read),
    .avm_write       (avm_write),
    .avm_writedata   (avm_writedata),
    .avm_readdata    (avm_readdata),
    .avm_waitrequest (avm_waitrequest),
    .evt_valid       (evt_valid),
    .evt_ready       (evt_ready),
    .evt_edges       (evt_edges),
    .evt_data        (evt_data),
    .init_done       (init_done),
    .err             (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          wr;
    logic [15:0] addr;
    logic [31:0] wd;
  } txn_t;

  txn_t        txlog[$];
  int          n_chk = 0;
  int          n_pass = 0;
  logic [9:0]  pio_edges = '0;
  logic [9:0]  pio_data  = '0;
  logic [9:0]  pio_mask  = '0;
  bit          force_irq = 0;
  bit          hang_rd0  = 0;
  int          stall_cfg = 0;
  int          stall_left = 0;
  int          n_stall = 0;
  bit          cmd_active = 0;
  bit          unstable = 0;
  bit          both_seen = 0;
  logic        snap_rd, snap_wr;
  logic [15:0] snap_addr;
  logic [31:0] snap_wd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // One clock: at the falling edge look at the registered command and answer it.
  task automatic tick();
    int unsigned idx;
    @(negedge clk);
    if (avm_read && avm_write) both_seen = 1;
    if (avm_read || avm_write) begin
      if (!cmd_active) begin
        cmd_active = 1;
        stall_left = stall_cfg;
        snap_rd = avm_read; snap_wr = avm_write;
        snap_addr = avm_address; snap_wd = avm_writedata;
      end else if (avm_read !== snap_rd || avm_write !== snap_wr ||
                   avm_address !== snap_addr || avm_writedata !== snap_wd) begin
        unstable = 1;
      end
      if (hang_rd0 && avm_read && avm_address == BASE) stall_left = 1000;
      if (stall_left > 0) begin
        stall_left--;
        n_stall++;
        avm_waitrequest = 1'b1;
        avm_readdata    = 32'hDEAD_BEEF;
      end else begin
        idx = 32'(avm_address - BASE) >> 2;
        avm_waitrequest = 1'b0;
        case (idx)
          0:       avm_readdata = {22'h2AAAAA, pio_data};
          2:       avm_readdata = {22'h155555, pio_mask};
          3:       avm_readdata = {22'h2AAAAA, pio_edges};
          default: avm_readdata = 32'hFFFF_FFFF;
        endcase
        txlog.push_back('{wr: avm_write, addr: avm_address, wd: avm_writedata});
        if (avm_write && idx == 3) pio_edges = '0;
        if (avm_write && idx == 2) pio_mask  = avm_writedata[9:0];
        cmd_active = 0;
      end
    end else begin
      cmd_active      = 0;
      avm_waitrequest = 1'b0;
      avm_readdata    = 32'hDEAD_BEEF;
    end
    pio_irq = (|pio_edges) | force_irq;
  endtask

  task automatic raise(input logic [9:0] e, input logic [9:0] d);
    pio_edges = e;
    pio_data  = d;
    pio_irq   = (|pio_edges) | force_irq;
  endtask

  task automatic wait_valid(input string tag, input int limit, output int n);
    n = 0;
    while (!evt_valid && n < limit) begin
      tick();
      n++;
    end
    chk({tag, "_valid_seen"}, evt_valid, 1'b1);
  endtask

  task automatic check_service(input string tag, input logic [9:0] e, input logic [9:0] d);
    chk({tag, "_ntxn"}, txlog.size(), 3);
    if (txlog.size() == 3) begin
      chk({tag, "_t0_rd_edge"}, {txlog[0].wr, txlog[0].addr}, {1'b0, BASE + 16'd12});
      chk({tag, "_t1_clr_edge"}, {txlog[1].wr, txlog[1].addr}, {1'b1, BASE + 16'd12});
      chk({tag, "_t1_wdata"}, txlog[1].wd, {22'b0, e});
      chk({tag, "_t2_rd_data"}, {txlog[2].wr, txlog[2].addr}, {1'b0, BASE});
    end
    chk({tag, "_edges"}, evt_edges, e);
    chk({tag, "_data"}, evt_data, d);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit bad;
    bit seen;
    logic [9:0] he, hd;

    reset = 1'b1; pio_irq = 1'b0; evt_ready = 1'b0;
    avm_waitrequest = 1'b0; avm_readdata = 32'hDEAD_BEEF;
    tick(); tick();
    chk("rst_read", avm_read, 1'b0);
    chk("rst_write", avm_write, 1'b0);
    chk("rst_addr", avm_address, BASE);
    chk("rst_wdata", avm_writedata, 32'h0);
    chk("rst_outs", {evt_valid, evt_edges, evt_data, init_done, err}, 24'h0);

    // Init: single mask write, then init_done.
    reset = 1'b0;
    n = 0;
    while (!init_done && n < 20) begin tick(); n++; end
    chk("init_done", init_done, 1'b1);
    chk("init_cycles", n, 2);
    chk("init_ntxn", txlog.size(), 1);
    if (txlog.size() == 1) begin
      chk("init_wr", {txlog[0].wr, txlog[0].addr}, {1'b1, BASE + 16'd8});
      chk("init_wdata", txlog[0].wd, 32'h3FF);
    end
    tick();
    chk("init_sticky", init_done, 1'b1);

    // Zero-wait service.
    txlog.delete(); unstable = 0;
    raise(10'h004, 10'h3FB);
    wait_valid("svc0", 20, n);
    chk("svc0_latency", n, 4);
    check_service("svc0", 10'h004, 10'h3FB);
    evt_ready = 1'b1;
    tick();
    chk("svc0_handshake", evt_valid, 1'b0);
    evt_ready = 1'b0;

    // Three wait states per command.
    txlog.delete(); unstable = 0; stall_cfg = 3;
    tick();
    raise(10'h201, 10'h155);
    wait_valid("svc3", 40, n);
    chk("svc3_latency", n, 13);
    check_service("svc3", 10'h201, 10'h155);
    chk("svc3_stable", unstable, 1'b0);
    evt_ready = 1'b1;
    tick();
    evt_ready = 1'b0;
    stall_cfg = 0;

    // Spurious irq; ready held high with nothing valid.
    txlog.delete(); evt_ready = 1'b1;
    force_irq = 1; pio_irq = 1'b1;
    tick();
    force_irq = 0; pio_irq = 1'b0;
    seen = 0;
    for (int i = 0; i < 8; i++) begin tick(); if (evt_valid) seen = 1; end
    chk("spur_no_valid", seen, 1'b0);
    chk("spur_ntxn", txlog.size(), 1);
    if (txlog.size() == 1)
      chk("spur_rd_edge", {txlog[0].wr, txlog[0].addr}, {1'b0, BASE + 16'd12});
    evt_ready = 1'b0;

    // Backpressure with irq re-asserted during REPORT.
    txlog.delete();
    raise(10'h080, 10'h001);
    wait_valid("bp", 20, n);
    check_service("bp", 10'h080, 10'h001);
    txlog.delete();
    raise(10'h010, 10'h2C3);
    he = evt_edges; hd = evt_data; bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (!evt_valid || evt_edges !== he || evt_data !== hd) bad = 1;
    end
    chk("bp_hold", bad, 1'b0);
    chk("bp_no_traffic", txlog.size(), 0);
    evt_ready = 1'b1;
    tick();
    evt_ready = 1'b0;
    chk("bp_released", evt_valid, 1'b0);
    tick();
    chk("bp_next_read", {avm_read, avm_address}, {1'b1, BASE + 16'd12});
    wait_valid("bp2", 20, n);
    check_service("bp2", 10'h010, 10'h2C3);
    evt_ready = 1'b1;
    tick();
    evt_ready = 1'b0;
    chk("no_rd_wr_overlap", both_seen, 1'b0);

`ifdef PIO_SVC_TIMEOUT_EN
    // Stuck waitrequest on the data read.
    txlog.delete(); hang_rd0 = 1; n_stall = 0;
    raise(10'h008, 10'h077);
    n = 0;
    while (!err && n < 40) begin tick(); n++; end
    chk("to_err", err, 1'b1);
    tick();
    chk("to_stall_count", n_stall, 9);
    chk("to_strobes_dropped", {avm_read, avm_write}, 2'b00);
    hang_rd0 = 0;
    tick(); tick();
    chk("to_err_sticky", err, 1'b1);
    chk("to_no_event", evt_valid, 1'b0);
    chk("to_ntxn", txlog.size(), 2);

    // Reset in the middle of a stalled read.
    stall_cfg = 5;
    raise(10'h001, 10'h000);
    n = 0;
    while (!avm_read && n < 10) begin tick(); n++; end
    chk("mid_rd_started", avm_read, 1'b1);
    reset = 1'b1;
    #1;
    chk("mid_rd_async_drop", avm_read, 1'b0);
    chk("mid_rd_err_clear", err, 1'b0);
`else
    chk("err_tied_low", err, 1'b0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
